// File: rtl/spmv_pkg.sv
// Shared SpMV constants, event encoding and collector state encoding.
package spmv_pkg;

  localparam int unsigned NUM_ROWS = 1120;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned QDEPTH   = 4;

  localparam logic EVT_DATA = 1'b1;
  localparam logic EVT_ZERO = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic              kind;
    logic [DATA_W-1:0] lane1;
    logic [DATA_W-1:0] lane0;
  } evt_t;

endpackage

// File: rtl/spmv_evt_queue.sv
// Small event FIFO: two ordered pushes and one pop per cycle; pushes that
// find no slot (after the same-cycle pop) are dropped and flagged.
module spmv_evt_queue
  import spmv_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_a,
  input  evt_t                   data_a,
  input  logic                   push_b,
  input  evt_t                   data_b,
  input  logic                   pop,
  output evt_t                   head_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_a_c,
  output logic                   drop_b_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  evt_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] slot_b;
  logic [CW:0]   free;
  logic          pop_ok;
  logic          acc_a;
  logic          acc_b;

  // Push a has priority for the last free slot.
  always_comb begin
    empty_c  = (count == '0);
    pop_ok   = pop && !empty_c;
    free     = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop_ok);
    acc_a    = push_a && (free != '0);
    acc_b    = push_b && (free > (CW+1)'(acc_a));
    drop_a_c = push_a && !acc_a;
    drop_b_c = push_b && !acc_b;
    slot_b   = wr_ptr + PW'(acc_a);
    head_c   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(acc_a) + PW'(acc_b);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_a) mem[wr_ptr] <= data_a;
    if (acc_b) mem[slot_b] <= data_b;
  end

endmodule

// File: rtl/spmv_result_collector.sv
// SpMV result sink: queues per-row result events, commits them in row order
// into a row-indexed buffer and serves host reads with one-cycle latency.
module spmv_result_collector
  import spmv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic              res_zeros,
  input  logic [DATA_W-1:0] res_lane0,
  input  logic [DATA_W-1:0] res_lane1,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   rows_written,
  output logic              err_overflow,
  output logic              err_extra
);

  localparam int unsigned        QCW      = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W:0]    ROWS_W   = (ADDR_W+1)'(NUM_ROWS);
  localparam logic [ADDR_W:0]    LAST_ROW = (ADDR_W+1)'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0]  ROWS_A   = ADDR_W'(NUM_ROWS);

  state_t               state;
  logic [ADDR_W-1:0]    row_idx;
  logic [2*DATA_W-1:0]  result_mem [NUM_ROWS];

  evt_t                 data_a_c;
  evt_t                 data_b_c;
  evt_t                 q_head_c;
  logic                 q_empty_c;
  logic [QCW-1:0]       q_count;
  logic                 q_drop_a_c;
  logic                 q_drop_b_c;
  logic                 capture_c;
  logic                 commit_c;
  logic                 flush_c;
  logic [2*DATA_W-1:0]  wr_word_c;
  logic                 rd_in_range_c;

  // A start cycle captures nothing; leftovers after the final commit are flushed.
  always_comb begin
    capture_c     = (state == ST_COLLECT) && !start;
    commit_c      = capture_c && !q_empty_c;
    flush_c       = start || ((state == ST_DONE) && (q_count != '0));
    data_a_c      = '{kind: EVT_DATA, lane1: res_lane1, lane0: res_lane0};
    data_b_c      = '{kind: EVT_ZERO, lane1: '0, lane0: '0};
    wr_word_c     = (q_head_c.kind == EVT_DATA) ? {q_head_c.lane1, q_head_c.lane0} : '0;
    rd_in_range_c = (rd_addr < ROWS_A);
  end

  spmv_evt_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_c),
    .push_a   (capture_c && res_valid),
    .data_a   (data_a_c),
    .push_b   (capture_c && res_zeros),
    .data_b   (data_b_c),
    .pop      (commit_c),
    .head_c   (q_head_c),
    .empty_c  (q_empty_c),
    .count    (q_count),
    .drop_a_c (q_drop_a_c),
    .drop_b_c (q_drop_b_c)
  );

  // Result buffer: lane1 in the upper half, lane0 in the lower half.
  always_ff @(posedge clk) begin
    if (rst && commit_c) result_mem[row_idx] <= wr_word_c;
  end

  // Read-first: a same-cycle commit is not visible to this read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_in_range_c) begin
          {rd_data1, rd_data0} <= result_mem[rd_addr];
        end else begin
          rd_data0 <= '0;
          rd_data1 <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      row_idx      <= '0;
      rows_written <= '0;
      err_overflow <= 1'b0;
      err_extra    <= 1'b0;
    end else if (start) begin
      state        <= ST_COLLECT;
      busy         <= 1'b1;
      done         <= 1'b0;
      row_idx      <= '0;
      rows_written <= '0;
      err_overflow <= 1'b0;
      err_extra    <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (q_drop_a_c || q_drop_b_c) err_overflow <= 1'b1;
          if (commit_c) begin
            row_idx <= row_idx + ADDR_W'(1);
            if (rows_written != ROWS_W) rows_written <= rows_written + (ADDR_W+1)'(1);
            if (rows_written == LAST_ROW) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          if (res_valid || res_zeros) err_extra <= 1'b1;
          if ((state == ST_DONE) && (q_count != '0)) err_overflow <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/spmv_result_collector.md
Name: spmv_result_collector

Overview:
- Sink end of the SpMV result stream; consumes the per-row result interface (valid, zeros, two 64-bit lane results).
- Reassembles results into a row-indexed result buffer, NUM_ROWS entries, one entry per sparse-matrix row, lanes 0/1 packed side by side.
- Host-side read port drains the buffer; done flags a complete matrix-vector product.

Parameters:
- NUM_ROWS, 1120, rows per product; buffer depth
- DATA_W, 64, width of each lane result
- ADDR_W, 11, row index width; must satisfy 2^ADDR_W >= NUM_ROWS
- QDEPTH, 4, event queue depth; power of two

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a new collection pass
- res_valid  in  1  row complete; lane data valid this cycle
- res_zeros  in  1  one empty row; writes zero
- res_lane0  in  DATA_W  lane 0 row result
- res_lane1  in  DATA_W  lane 1 row result
- rd_en  in  1  host read request
- rd_addr  in  ADDR_W  host read row index
- rd_data0  out  DATA_W  lane 0 read data
- rd_data1  out  DATA_W  lane 1 read data
- rd_valid  out  1  read data valid
- busy  out  1  pass in progress
- done  out  1  all NUM_ROWS rows written; held until start or reset
- rows_written  out  ADDR_W+1  rows committed this pass
- err_overflow  out  1  sticky; event dropped on full queue
- err_extra  out  1  sticky; event arrived outside COLLECT

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; all outputs 0; queue emptied; row index 0; buffer contents undefined. Reset mid-pass abandons the pass with no further writes.
- States:
  - IDLE: busy=0. start goes to COLLECT.
  - COLLECT: busy=1. Goes to DONE on the cycle the NUM_ROWS-th row commits.
  - DONE: done=1, busy=0. start goes to COLLECT.
- start: clears the row index, rows_written, the queue, done, err_overflow and err_extra. start in COLLECT restarts the pass.
- Event capture, COLLECT only:
  - res_valid pushes a DATA event {lane1, lane0}.
  - res_zeros pushes a ZERO event.
  - Both in the same cycle push DATA first, then ZERO (two pushes).
- Queue:
  - Holds QDEPTH entries; up to 2 pushes and 1 pop per cycle.
  - A push that finds no free slot after the same-cycle pop is dropped and sets err_overflow.
  - If only one slot is free on a double push, DATA is kept and ZERO is dropped.
- Commit:
  - One pop per cycle while the queue is non-empty in COLLECT.
  - Writes the buffer at the row index: DATA writes the lanes; ZERO writes 0 to both lanes.
  - Row index and rows_written increment on each commit.
  - Latency from event to buffer write is at least 1 cycle.
  - Queue entries left after the final commit are discarded and set err_overflow.
- Events in IDLE/DONE are ignored and set err_extra; the buffer is unchanged.
- Read port:
  - Fixed 1-cycle latency: rd_valid and rd_data follow rd_en by one clock.
  - Works in any state.
  - rd_addr >= NUM_ROWS returns 0 with rd_valid=1.
  - A same-cycle read and commit to the same row returns the old contents (read-first).
- Width rules: no arithmetic on data; the row index wraps only via start; rows_written saturates at NUM_ROWS.

Decomposition:
- Shared package spmv_pkg:
  - constants NUM_ROWS, DATA_W, ADDR_W.
  - event-kind encoding EVT_DATA=1'b1, EVT_ZERO=1'b0.
  - state encoding ST_IDLE, ST_COLLECT, ST_DONE.
  - The SpMV core uses the same constants.
- One sub-module: spmv_evt_queue, a QDEPTH x (1+2*DATA_W) FIFO with dual push, single pop, count and drop outputs.
- Result buffer is an inferred simple dual-port array inside the top level.

Test Plan:
- Reset then start; res_valid with lane0=5, lane1=7, then lane0=9, lane1=11; read rows 0 and 1 -> (5,7), (9,11); rows_written=2; rd_valid exactly 1 cycle after rd_en.
- Same-cycle res_valid (lane0=3, lane1=4) and res_zeros -> row0=(3,4), row1=(0,0); rows_written=2; err_overflow=0.
- 6 double events on consecutive cycles (12 pushes) with QDEPTH=4 -> err_overflow=1; rows_written equals the accepted count; no row skipped.
- Full pass of 1120 res_valid events (lane0=row, lane1=~row), one every 28 cycles -> done=1 after the 1120th commit; busy=0; read row 1119 -> (1119, ~1119).
- res_valid in DONE -> err_extra=1; row 0 unchanged; next start clears err_extra and done.
- rst=0 after 10 commits, then start with 2 events -> rows_written=2; rows 0/1 hold the new data; all outputs were 0 the cycle after reset.
